apb_setup_node: RTL and testbench

- Downstream neighbour of the LINT-to-APB bridge.
- The bridge raises PSEL and PENABLE in the same cycle, with no APB setup phase. This node accepts that form, and also accepts compliant APB.
- It regenerates a compliant SETUP→ACCESS sequence toward one of NB_SLAVES peripherals, selected by a run-time address map.
- It ends every transfer toward the bridge with exactly one PREADY pulse. Unmapped addresses and hung slaves both end with an error response.

---
 rtl/apb_setup_node.sv | 180 ++++++++++++++++++
 tb/tb_apb_setup_node.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_setup_node.sv
// apb_setup_node
// ---------------------------------------------------------------------------
// Sits downstream of the LINT-to-APB bridge. The bridge raises PSEL and
// PENABLE together (no setup phase); compliant APB masters are accepted too,
// since a transfer starts on s_PSEL alone. The node decodes the address
// against a run-time map, then drives a compliant SETUP -> ACCESS sequence
// toward the selected slave. Every transfer ends with a single s_PREADY
// pulse. Unmapped addresses and slaves that never answer both end with an
// error response carrying ERR_RDATA.
//
// Handshake: upstream s_PSEL=1 seen in IDLE starts a transfer. s_PADDR,
// s_PWDATA and s_PWRITE are latched on that cycle. Completion is the single
// cycle with s_PREADY=1, and s_PRDATA/s_PSLVERR are valid in that cycle.
// Downstream follows APB: SETUP (PSEL=1, PENABLE=0) for one cycle, then
// ACCESS (PSEL=1, PENABLE=1) until m_PREADY[idx]=1 or the timeout expires.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start_addr_i           region base per slave (slice i = slave i)
//   end_addr_i             region end per slave (exclusive)
//   s_P*                   upstream APB-like port (from the bridge)
//   m_P*                   downstream APB port, shared buses, one-hot PSEL
// ---------------------------------------------------------------------------
module apb_setup_node #(
  parameter int          NB_SLAVES      = 4,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hBADACCE5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] end_addr_i,
  input  logic [ADDR_WIDTH-1:0]           s_PADDR,
  input  logic [DATA_WIDTH-1:0]           s_PWDATA,
  input  logic                            s_PWRITE,
  input  logic                            s_PSEL,
  input  logic                            s_PENABLE,
  output logic [DATA_WIDTH-1:0]           s_PRDATA,
  output logic                            s_PREADY,
  output logic                            s_PSLVERR,
  output logic [ADDR_WIDTH-1:0]           m_PADDR,
  output logic [DATA_WIDTH-1:0]           m_PWDATA,
  output logic                            m_PWRITE,
  output logic [NB_SLAVES-1:0]            m_PSEL,
  output logic                            m_PENABLE,
  input  logic [NB_SLAVES*DATA_WIDTH-1:0] m_PRDATA,
  input  logic [NB_SLAVES-1:0]            m_PREADY,
  input  logic [NB_SLAVES-1:0]            m_PSLVERR
);

  localparam int IDX_W = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;
  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_RDATA);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_ERR    = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt_q;

  // Start detection relies on s_PSEL only; s_PENABLE carries no information
  // for this node.
  logic unused_penable;
  assign unused_penable = s_PENABLE;

  // Address decode. Scanning from the top index down lets the lowest
  // matching index overwrite the others, so it wins on overlap. The two-sided
  // compare already rejects regions with start >= end.
  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NB_SLAVES - 1; i >= 0; i--) begin
      if ((start_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] <= s_PADDR) &&
          (s_PADDR < end_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Response mux for the selected slave and one-hot select vector.
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [NB_SLAVES-1:0]  psel_onehot;

  always_comb begin
    sel_ready   = 1'b0;
    sel_err     = 1'b0;
    sel_rdata   = '0;
    psel_onehot = '0;
    for (int i = 0; i < NB_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready      = m_PREADY[i];
        sel_err        = m_PSLVERR[i];
        sel_rdata      = m_PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
        psel_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_PSEL) begin
            addr_q  <= s_PADDR;
            wdata_q <= s_PWDATA;
            write_q <= s_PWRITE;
            idx_q   <= hit_idx;
            state   <= hit ? ST_SETUP : ST_ERR;
          end
        end
        ST_SETUP: begin
          cnt_q <= '0;
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A PREADY arriving on the last allowed cycle beats the timeout.
          if (sel_ready) begin
            rdata_q <= sel_rdata;
            err_q   <= sel_err;
            state   <= ST_RESP;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_ERR: begin
          rdata_q <= ERR_DATA;
          err_q   <= 1'b1;
          state   <= ST_RESP;
        end
        // s_PSEL is deliberately not looked at here: an upstream holding
        // PSEL through PREADY must not start a second transfer.
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_PSEL    = ((state == ST_SETUP) || (state == ST_ACCESS)) ? psel_onehot : '0;
  assign m_PENABLE = (state == ST_ACCESS);
  assign m_PADDR   = addr_q;
  assign m_PWDATA  = wdata_q;
  assign m_PWRITE  = write_q;
  assign s_PREADY  = (state == ST_RESP);
  assign s_PRDATA  = rdata_q;
  assign s_PSLVERR = err_q;

endmodule

// File: tb/tb_apb_setup_node.sv
module tb_apb_setup_node;

  localparam int NB  = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam logic [31:0] ERRD = 32'hBADACCE5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NB*AW-1:0] start_addr, end_addr;
  logic [AW-1:0]    s_PADDR;
  logic [DW-1:0]    s_PWDATA;
  logic             s_PWRITE, s_PSEL, s_PENABLE;
  logic [DW-1:0]    s_PRDATA;
  logic             s_PREADY, s_PSLVERR;
  logic [AW-1:0]    m_PADDR;
  logic [DW-1:0]    m_PWDATA;
  logic             m_PWRITE;
  logic [NB-1:0]    m_PSEL;
  logic             m_PENABLE;
  logic [NB*DW-1:0] m_PRDATA;
  logic [NB-1:0]    m_PREADY, m_PSLVERR;

  apb_setup_node #(
    .NB_SLAVES(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERRD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_addr_i(start_addr), .end_addr_i(end_addr),
    .s_PADDR(s_PADDR), .s_PWDATA(s_PWDATA), .s_PWRITE(s_PWRITE),
    .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE),
    .s_PRDATA(s_PRDATA), .s_PREADY(s_PREADY), .s_PSLVERR(s_PSLVERR),
    .m_PADDR(m_PADDR), .m_PWDATA(m_PWDATA), .m_PWRITE(m_PWRITE),
    .m_PSEL(m_PSEL), .m_PENABLE(m_PENABLE),
    .m_PRDATA(m_PRDATA), .m_PREADY(m_PREADY), .m_PSLVERR(m_PSLVERR)
  );

  // ---------------- slave models ----------------
  // Both slaves share one configuration; slave i returns cfg_rdata + i so a
  // wrong selection shows up in the read data.
  int          cfg_wait  = 0;
  logic [31:0] cfg_rdata = '0;
  logic        cfg_err   = 1'b0;
  logic        cfg_hang  = 1'b0;
  int          acc_cnt   = 0;
  logic [31:0] wr_addr   = '0;
  logic [31:0] wr_data   = '0;
  int          wr_cnt    = 0;

  always @(posedge clk) begin
    acc_cnt <= (m_PENABLE && (m_PSEL != '0)) ? acc_cnt + 1 : 0;
    if (m_PENABLE && m_PWRITE && ((m_PSEL & m_PREADY) != '0)) begin
      wr_addr <= m_PADDR;
      wr_data <= m_PWDATA;
      wr_cnt  <= wr_cnt + 1;
    end
  end

  always_comb begin
    m_PREADY  = '0;
    m_PSLVERR = '0;
    m_PRDATA  = '0;
    for (int i = 0; i < NB; i++) begin
      m_PREADY[i]           = m_PSEL[i] && m_PENABLE && !cfg_hang && (acc_cnt == cfg_wait);
      m_PSLVERR[i]          = cfg_err;
      m_PRDATA[i*DW +: DW]  = cfg_rdata + 32'(i);
    end
  end

  // ---------------- address map ----------------
  logic [31:0] map_start [NB];
  logic [31:0] map_end   [NB];

  task automatic set_map(input int m);
    map_start[0] = 32'h1A10_0000; map_end[0] = 32'h1A10_1000;
    map_start[1] = 32'h1A10_1000; map_end[1] = 32'h1A10_2000;
    if (m == 1) map_start[1] = 32'h1A10_0000;                          // overlap
    if (m == 2) begin map_start[0] = 32'h1A10_1000; map_end[0] = 32'h1A10_0000; end // empty
    start_addr = {map_start[1], map_start[0]};
    end_addr   = {map_end[1],   map_end[0]};
  endtask

  // ---------------- reference model ----------------
  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < NB; i++)
      if (map_start[i] <= a && a < map_end[i]) return i;
    return -1;
  endfunction

  // Cycles from the start edge to the s_PREADY pulse.
  function automatic int model_lat(input int idx);
    if (idx < 0) return 2;
    if (cfg_hang || cfg_wait >= TO) return TO + 2;
    return 3 + cfg_wait;
  endfunction

  function automatic logic model_ok(input int idx);
    return (idx >= 0) && !cfg_hang && (cfg_wait < TO);
  endfunction

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    s_PSEL = 1'b0; s_PENABLE = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge with the DUT idle; returns at a falling
  // edge with the DUT idle again.
  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic write, input logic compliant, input logic hold,
                          input int exp_idx, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    bit done;
    int wr_before;
    logic [1:0] exp_sel;
    exp_sel   = (exp_idx < 0) ? 2'b00 : 2'(1 << exp_idx);
    wr_before = wr_cnt;
    s_PADDR = addr; s_PWDATA = wdata; s_PWRITE = write;
    s_PSEL = 1'b1; s_PENABLE = !compliant;
    n = 0; done = 0;
    exp_q.push_back(exp_rdata);
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      s_PENABLE = 1'b1;
      if (s_PREADY) done = 1;
      else begin
        chk("phase_sel_en", {m_PSEL, m_PENABLE}, {exp_sel, (exp_idx >= 0) && (n >= 2)});
        if (n == 1 && exp_idx >= 0)
          chk("setup_bus", {m_PADDR, m_PWDATA, m_PWRITE}, {addr, wdata, write});
      end
    end
    if (!done) begin
      chk("pready_wait_budget", 0, 1);
      void'(exp_q.pop_front());
      reset_dut();
      return;
    end
    chk("latency", n, exp_lat);
    chk("prdata", s_PRDATA, exp_q.pop_front());
    chk("pslverr", s_PSLVERR, exp_err);
    chk("resp_downstream_idle", {m_PSEL, m_PENABLE}, 3'b000);
    if (exp_idx >= 0 && !exp_err && write)
      chk("slave_write", {wr_cnt - wr_before, wr_addr, wr_data}, {32'd1, addr, wdata});
    if (!hold) begin s_PSEL = 1'b0; s_PENABLE = 1'b0; end
    @(negedge clk);
    chk("pready_single_pulse", s_PREADY, 1'b0);
    chk("prdata_held", {s_PRDATA, s_PSLVERR}, {exp_rdata, exp_err});
    if (hold) begin
      chk("no_reaccept_in_resp", m_PSEL, 2'b00);
      s_PSEL = 1'b0; s_PENABLE = 1'b0;
      @(negedge clk);
      chk("idle_after_hold", {m_PSEL, s_PREADY}, 3'b000);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        compliant;
    int          map_id;
    int          wait_st;
    logic [31:0] sl_rdata;
    logic        sl_err;
    logic        sl_hang;
    int          exp_idx;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{32'h1A10_1004, 32'hCAFE_0001, 1'b1, 1'b0, 0, 0, 32'h0000_0000, 1'b0, 1'b0,  1,  3, 32'h0000_0001, 1'b0};
    vecs[1]  = '{32'h1A10_0008, 32'h0,         1'b0, 1'b1, 0, 2, 32'h1234_5678, 1'b0, 1'b0,  0,  5, 32'h1234_5678, 1'b0};
    vecs[2]  = '{32'h2000_0000, 32'h0,         1'b0, 1'b0, 0, 0, 32'h0000_0000, 1'b0, 1'b0, -1,  2, 32'hBADA_CCE5, 1'b1};
    vecs[3]  = '{32'h1A10_1010, 32'h0,         1'b0, 1'b0, 0, 0, 32'h0000_1111, 1'b0, 1'b1,  1, 10, 32'hBADA_CCE5, 1'b1};
    vecs[4]  = '{32'h1A10_0010, 32'h0,         1'b0, 1'b0, 0, 1, 32'hDEAD_0000, 1'b1, 1'b0,  0,  4, 32'hDEAD_0000, 1'b1};
    vecs[5]  = '{32'h1A10_0000, 32'h0,         1'b0, 1'b0, 1, 0, 32'h55AA_0000, 1'b0, 1'b0,  0,  3, 32'h55AA_0000, 1'b0};
    vecs[6]  = '{32'h1A10_1FFC, 32'h0,         1'b0, 1'b0, 0, 7, 32'h0000_0010, 1'b0, 1'b0,  1, 10, 32'h0000_0011, 1'b0};
    vecs[7]  = '{32'h1A10_1000, 32'h0,         1'b0, 1'b0, 0, 8, 32'h0000_0020, 1'b0, 1'b0,  1, 10, 32'hBADA_CCE5, 1'b1};
    vecs[8]  = '{32'h1A10_2000, 32'h0,         1'b0, 1'b0, 0, 0, 32'h0000_0000, 1'b0, 1'b0, -1,  2, 32'hBADA_CCE5, 1'b1};
    vecs[9]  = '{32'h1A0F_FFFC, 32'h0,         1'b0, 1'b1, 0, 0, 32'h0000_0000, 1'b0, 1'b0, -1,  2, 32'hBADA_CCE5, 1'b1};
    vecs[10] = '{32'h1A10_0008, 32'h0,         1'b0, 1'b0, 2, 0, 32'h0000_0000, 1'b0, 1'b0, -1,  2, 32'hBADA_CCE5, 1'b1};
    vecs[11] = '{32'h1A10_1008, 32'h0,         1'b0, 1'b0, 2, 0, 32'h0000_0077, 1'b0, 1'b0,  1,  3, 32'h0000_0078, 1'b0};
    vecs[12] = '{32'h1A10_1800, 32'h0BAD_F00D, 1'b1, 1'b1, 1, 3, 32'h0000_0100, 1'b0, 1'b0,  1,  6, 32'h0000_0101, 1'b0};
  end

  // ---------------- main sequence ----------------
  initial begin
    int r, idx;
    logic [31:0] a, wd;
    logic wr;
    rst_n = 1'b0;
    s_PADDR = '0; s_PWDATA = '0; s_PWRITE = 1'b0; s_PSEL = 1'b0; s_PENABLE = 1'b0;
    set_map(0);
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {m_PSEL, m_PENABLE, s_PREADY, s_PSLVERR, s_PRDATA, m_PADDR, m_PWDATA, m_PWRITE},
        '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      set_map(vecs[v].map_id);
      cfg_wait = vecs[v].wait_st; cfg_rdata = vecs[v].sl_rdata;
      cfg_err = vecs[v].sl_err;   cfg_hang = vecs[v].sl_hang;
      run_xfer(vecs[v].addr, vecs[v].wdata, vecs[v].write, vecs[v].compliant, 1'b0,
               vecs[v].exp_idx, vecs[v].exp_lat, vecs[v].exp_rdata, vecs[v].exp_err);
    end

    // Upstream holds PSEL through the PREADY cycle.
    set_map(0);
    cfg_wait = 0; cfg_rdata = 32'h0000_0ABC; cfg_err = 1'b0; cfg_hang = 1'b0;
    run_xfer(32'h1A10_0100, 32'h0, 1'b0, 1'b0, 1'b1, 0, 3, 32'h0000_0ABC, 1'b0);

    // Reset in the middle of ACCESS.
    cfg_hang = 1'b1;
    s_PADDR = 32'h1A10_1010; s_PWDATA = 32'hFEED_BEEF; s_PWRITE = 1'b1;
    s_PSEL = 1'b1; s_PENABLE = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_reset_in_access", {m_PSEL, m_PENABLE}, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {m_PSEL, m_PENABLE, s_PREADY, s_PSLVERR, s_PRDATA, m_PADDR, m_PWDATA, m_PWRITE},
        '0);
    s_PSEL = 1'b0; s_PENABLE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_pready_in_reset", s_PREADY, 1'b0);
    end
    rst_n = 1'b1;
    cfg_hang = 1'b0;
    @(negedge clk);
    chk("no_pready_after_reset", {s_PREADY, m_PSEL}, 3'b000);
    cfg_wait = 1; cfg_rdata = 32'h0000_2220;
    run_xfer(32'h1A10_1020, 32'h1357_9BDF, 1'b1, 1'b0, 1'b0, 1, 4, 32'h0000_2221, 1'b0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      set_map($urandom_range(0, 2));
      r = $urandom_range(0, 4);
      case (r)
        0: a = 32'h1A10_0000 + ($urandom_range(0, 32'hFFF) & ~32'h3);
        1: a = 32'h1A10_1000 + ($urandom_range(0, 32'hFFF) & ~32'h3);
        2: a = 32'h1A0F_F000 + ($urandom_range(0, 32'hFFF) & ~32'h3);
        3: a = 32'h1A10_2000 + ($urandom_range(0, 32'hFFF) & ~32'h3);
        default: a = $urandom;
      endcase
      wd = $urandom;
      wr = 1'($urandom_range(0, 1));
      cfg_wait  = $urandom_range(0, 9);
      cfg_hang  = ($urandom_range(0, 9) == 0);
      cfg_err   = 1'($urandom_range(0, 1));
      cfg_rdata = $urandom;
      idx = model_decode(a);
      run_xfer(a, wd, wr, 1'($urandom_range(0, 1)), 1'b0, idx, model_lat(idx),
               model_ok(idx) ? cfg_rdata + 32'(idx) : ERRD,
               model_ok(idx) ? cfg_err : 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
